hamming_link_arb: RTL
=====================

HAMMING_LINK_ARB -- requirements
Module: hamming_link_arb

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter NREQ, default 2, SHALL set the number of requesters sharing one Hamming codec link (legal range 1..8).
REQ-003 Parameter RSP_LAT, default 3, SHALL set the cycles between the last bit written to the codec and the first decoded bit read back (legal range 1..255).
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port req  input  NREQ  per-requester request, held high until granted.
REQ-007 Port req_data  input  4*NREQ  per-requester nibble; requester i uses bits [4i+3:4i].
REQ-008 Port gnt  output  NREQ  one-hot grant pulse, one cycle wide.
REQ-009 Port codec_serial_in  output  1  serial data bit driven into the codec.
REQ-010 Port codec_write  output  1  codec write strobe, high while a data bit is presented.
REQ-011 Port codec_serial_out  input  1  decoded serial bit returned by the codec.
REQ-012 Port rsp_valid  output  1  one-cycle pulse marking a completed transaction.
REQ-013 Port rsp_id  output  max(1,clog2(NREQ))  index of the requester that owns the response.
REQ-014 Port rsp_data  output  4  decoded nibble.
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port err_cnt  output  8  saturating count of responses whose rsp_data differs from the nibble that was sent.

Function
REQ-017 The FSM SHALL have five states, IDLE, SEND, WAIT, RECV and DONE, with all outputs registered.
REQ-018 IDLE: when any req bit is high, the next state SHALL be SEND; otherwise the FSM SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: the winner is the first asserted req index found at or after (last_gnt+1) mod NREQ, searching upward with wrap.
REQ-020 On the IDLE->SEND edge the block SHALL capture the winner's nibble and index and update last_gnt; gnt[winner] SHALL be high for exactly the first SEND cycle.
REQ-021 Only req values sampled in IDLE SHALL be considered; a req raised and dropped outside IDLE SHALL never be granted.
REQ-022 SEND SHALL last 4 cycles with codec_write=1 and codec_serial_in=nibble bit k in SEND cycle k (k=0..3, LSB first), then go to WAIT.
REQ-023 WAIT SHALL last exactly RSP_LAT cycles with codec_write=0 and codec_serial_in=0, then go to RECV.
REQ-024 RECV SHALL last 4 cycles, sampling codec_serial_out into rsp_data bit k in RECV cycle k (LSB first), then go to DONE.
REQ-025 DONE SHALL last 1 cycle with rsp_valid=1, rsp_id=captured index and rsp_data=received nibble, then return to IDLE.
REQ-026 rsp_valid SHALL rise exactly 8+RSP_LAT cycles after the gnt cycle; there is no back-pressure on the response.
REQ-027 rsp_data and rsp_id SHALL hold their values until the next DONE.
REQ-028 In DONE, if rsp_data differs from the sent nibble and err_cnt<255, err_cnt SHALL increment by 1; at 255 it SHALL hold.
REQ-029 codec_write SHALL be 0 in every state except SEND.
REQ-030 Back-to-back transactions: a req still high in the cycle after DONE SHALL be granted with no extra idle cycle; minimum period is 10+RSP_LAT cycles.
REQ-031 With NREQ=1, every request SHALL be granted to index 0 and rsp_id SHALL be 0.

Reset
REQ-032 While rst_n=0 (asynchronous assert, including mid-transaction), the block SHALL immediately set state=IDLE, gnt=0, codec_write=0, codec_serial_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, err_cnt=0, busy=0 and last_gnt=NREQ-1.
REQ-033 An in-flight transaction interrupted by reset SHALL be discarded with no rsp_valid; after release, the first grant SHALL go to the lowest asserted index.

Verification
REQ-034 Loopback test (codec model echoes with RSP_LAT=3): req[0]=1, data0=4'hA -> gnt[0] pulse; codec_write high 4 cycles with serial bits 0,1,0,1; rsp_valid 11 cycles after gnt with rsp_id=0, rsp_data=A, err_cnt=0.
REQ-035 Round-robin test: req=2'b11 held for three transactions -> grant order 0,1,0; gnt always one-hot and single-cycle.
REQ-036 Error test: codec model flips bit 2 on the return path, send 4'h3 -> rsp_data=4'h7 and err_cnt=1; 300 corrupted transactions -> err_cnt=255.
REQ-037 Reset mid-SEND: assert rst_n=0 in SEND cycle 2 -> codec_write=0 immediately, no rsp_valid; after release with req=2'b10, gnt[1] fires first.
REQ-038 Back-to-back test: req[1] held continuously with RSP_LAT=1 -> successive gnt pulses exactly 11 cycles apart; busy low for exactly 1 cycle between transactions.

Source files
------------

// File: rtl/hamming_link_arb.sv
// rtl/hamming_link_arb.sv - round-robin arbiter that serialises requester nibbles through a shared codec link
//
// Requesters are sampled only while IDLE. The winner's nibble is shifted out LSB first
// for four cycles. The block then waits RSP_LAT cycles and shifts four decoded bits back in.
// The result is reported for one cycle in DONE. Every output is a flop, so busy, gnt and
// the codec strobes line up exactly with the state that owns them.
module hamming_link_arb #(
  parameter int NREQ    = 2,
  parameter int RSP_LAT = 3,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              codec_serial_in,
  output logic              codec_write,
  input  logic              codec_serial_out,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_data,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  localparam logic [IDW-1:0] LAST_RST  = IDW'(NREQ - 1);
  localparam logic [7:0]     WAIT_LAST = 8'(RSP_LAT - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      nib_q, nib_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [3:0]      rx_q, rx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            wr_q, wr_d;
  logic            sin_q, sin_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [3:0]      rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;
  logic [7:0]      err_q, err_d;

  logic [IDW-1:0]  win;
  logic            win_found;
  logic [1:0]      nxt_bit;

  // Round-robin pick: the first asserted request after last_gnt, wrapping, with last_gnt itself tried last
  always_comb begin
    win       = last_q;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win       = IDW'(idx);
        win_found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nib_d       = nib_q;
    id_d        = id_q;
    last_d      = last_q;
    rx_d        = rx_q;
    gnt_d       = '0;
    wr_d        = 1'b0;
    sin_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    nxt_bit     = cnt_q[1:0] + 2'd1;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = SEND;
          cnt_d      = 8'd0;
          nib_d      = req_data[int'(win)*4 +: 4];
          id_d       = win;
          last_d     = win;
          gnt_d[win] = 1'b1;
          wr_d       = 1'b1;
          sin_d      = nib_d[0];
        end
      end
      SEND: begin
        if (cnt_q[1:0] == 2'd3) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          wr_d  = 1'b1;
          sin_d = nib_q[nxt_bit];
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = RECV;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RECV: begin
        rx_d[cnt_q[1:0]] = codec_serial_out;
        if (cnt_q[1:0] == 2'd3) begin
          state_d     = DONE;
          cnt_d       = 8'd0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = rx_d;
          if (rx_d != nib_q && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      nib_q       <= 4'd0;
      id_q        <= '0;
      last_q      <= LAST_RST;
      rx_q        <= 4'd0;
      gnt_q       <= '0;
      wr_q        <= 1'b0;
      sin_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 4'd0;
      busy_q      <= 1'b0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nib_q       <= nib_d;
      id_q        <= id_d;
      last_q      <= last_d;
      rx_q        <= rx_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      sin_q       <= sin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign gnt             = gnt_q;
  assign codec_write     = wr_q;
  assign codec_serial_in = sin_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_data        = rsp_data_q;
  assign busy            = busy_q;
  assign err_cnt         = err_q;

endmodule
